// File: rtl/pulse_generator_pkg.sv
// rtl/pulse_generator_pkg.sv - state encoding and bus-width helper for pulse_generator
package pulse_generator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Bits needed to hold any value in 0..max_value inclusive.
  function automatic int calc_width(input int max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/pulse_generator_rise_detect.sv
// rtl/pulse_generator_rise_detect.sv - rising-edge detector; history clears in reset
module rise_detect (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic sig,
  output logic rise
);

  logic prev;

  // Clearing history makes a level held high through reset count as a fresh edge.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      prev <= 1'b0;
    end else begin
      prev <= sig;
    end
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - emits an enable pulse of a requested cycle count, then a done strobe
// Optional macro PULSE_GEN_REPEAT_EN adds repeat_i for a periodic pulse train.
module pulse_generator #(
  parameter int MAX_PULSE_WIDTH = 2000,
  localparam int WIDTH = pulse_generator_pkg::calc_width(MAX_PULSE_WIDTH)
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] width_i,
  input  logic             abort_i,
`ifdef PULSE_GEN_REPEAT_EN
  input  logic             repeat_i,
`endif
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [WIDTH-1:0] remaining_o
);

  import pulse_generator_pkg::*;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_PULSE_WIDTH);

  state_t           state;
  state_t           state_n;
  logic             start_rise;
  logic [WIDTH-1:0] req_w;
  logic [WIDTH-1:0] rem_n;
  logic             pulse_n;
  logic             busy_n;
  logic             done_n;
  logic             aborted_n;

  rise_detect u_start_rise (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .sig       (start_i),
    .rise      (start_rise)
  );

  assign req_w = (width_i > MAX_W) ? MAX_W : width_i;

`ifdef PULSE_GEN_REPEAT_EN
  logic [WIDTH-1:0] cap_w;

  // Held so DONE can relaunch the same width without another start edge.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      cap_w <= '0;
    end else if (state == IDLE && start_rise) begin
      cap_w <= req_w;
    end
  end
`endif

  always_comb begin
    state_n   = state;
    rem_n     = remaining_o;
    aborted_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_rise) begin
          if (req_w != '0) begin
            state_n = ACTIVE;
            rem_n   = req_w;
          end else begin
            state_n = DONE;
            rem_n   = '0;
          end
        end
      end
      ACTIVE: begin
        // Abort takes priority over natural expiry on the last cycle.
        if (abort_i) begin
          state_n   = DONE;
          rem_n     = '0;
          aborted_n = 1'b1;
        end else if (remaining_o == WIDTH'(1)) begin
          state_n = DONE;
          rem_n   = '0;
        end else begin
          rem_n = remaining_o - WIDTH'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        rem_n   = '0;
`ifdef PULSE_GEN_REPEAT_EN
        if (repeat_i && !aborted_o && cap_w != '0) begin
          state_n = ACTIVE;
          rem_n   = cap_w;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        rem_n   = '0;
      end
    endcase
    pulse_n = (state_n == ACTIVE);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      pulse_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      aborted_o   <= 1'b0;
      remaining_o <= '0;
    end else begin
      state       <= state_n;
      pulse_o     <= pulse_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      aborted_o   <= aborted_n;
      remaining_o <= rem_n;
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// tb/tb_pulse_generator.sv - self-checking bench for pulse_generator
module tb_pulse_generator;

  localparam int MAXW = 2000;
  localparam int WB   = $clog2(MAXW + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rep   = 1'b0;
  logic [WB-1:0] width = '0;
  logic          pulse;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [WB-1:0] remaining;

  always #5 clk = ~clk;

  pulse_generator #(.MAX_PULSE_WIDTH(MAXW)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .start_i     (start),
    .width_i     (width),
    .abort_i     (abort),
`ifdef PULSE_GEN_REPEAT_EN
    .repeat_i    (rep),
`endif
    .pulse_o     (pulse),
    .busy_o      (busy),
    .done_o      (done),
    .aborted_o   (aborted),
    .remaining_o (remaining)
  );

  int errors = 0;
  int checks = 0;

  // Reference: the current request as cycle intervals [ps..pe] high, done at dc.
  int cyc  = 0;
  int ps   = 1;
  int pe   = 0;
  int wend = 0;
  int dc   = -10;
  int wcap = 0;
  bit prev = 1'b0;
  bit abt  = 1'b0;

  int pulse_cnt = 0;
  int done_cnt  = 0;
  int dur_cnt   = 0;
  bit dur_fin   = 1'b0;
  bit dur_prev  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int  c;
    int  w;
    bit  rise;
    c = cyc;
    if (!rst_n) begin
      prev = 1'b0; ps = 1; pe = 0; wend = 0; dc = -10; abt = 1'b0;
    end else begin
      rise = start && !prev;
      prev = start;
      if (abort && c >= ps && c <= pe) begin
        pe = c; dc = c + 1; abt = 1'b1;
      end else if (c > dc && rise) begin
        w = (int'(width) > MAXW) ? MAXW : int'(width);
        ps = c + 1; pe = c + w; wend = c + w; dc = c + w + 1; abt = 1'b0; wcap = w;
      end
`ifdef PULSE_GEN_REPEAT_EN
      else if (c == dc && rep && !abt && wcap > 0) begin
        ps = c + 1; pe = c + wcap; wend = pe; dc = c + wcap + 1;
      end
`endif
    end
  endtask

  task automatic tick();
    int n;
    int ev;
    int av;
    bit ep;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    n  = cyc;
    ep = (n >= ps && n <= pe);
    ev = (int'(ep) << 14) | (int'(n >= ps && n <= dc) << 13) | (int'(n == dc) << 12)
       | (int'(n == dc && abt) << 11) | (ep ? (wend - n + 1) : 0);
    av = (int'(pulse) << 14) | (int'(busy) << 13) | (int'(done) << 12)
       | (int'(aborted) << 11) | int'(remaining);
    chk("outputs_vs_model", av, ev);
    if (pulse) pulse_cnt++;
    if (done) done_cnt++;
    if (pulse) begin
      dur_cnt = dur_prev ? dur_cnt + 1 : 0;
      dur_fin = 1'b0;
    end else if (dur_prev) begin
      dur_fin = 1'b1;
    end
    dur_prev = pulse;
  endtask

  typedef struct {
    int w;
    int abort_at;
    int exp_len;
    bit exp_ab;
  } vec_t;

  vec_t vecs[8];
  int   k;
  int   n0;
  int   dcyc;
  bit   seen;
  bit   ab;

  initial begin
    vecs[0] = '{5,    -1, 5,    1'b0};
    vecs[1] = '{0,    -1, 0,    1'b0};
    vecs[2] = '{2047, -1, 2000, 1'b0};
    vecs[3] = '{100,   2, 3,    1'b1};
    vecs[4] = '{7,     6, 7,    1'b1};
    vecs[5] = '{1,    -1, 1,    1'b0};
    vecs[6] = '{1,     0, 1,    1'b1};
    vecs[7] = '{2000, -1, 2000, 1'b0};

    repeat (3) tick();
    chk("reset_pulse", int'(pulse), 0);
    chk("reset_remaining", int'(remaining), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      width = WB'(vecs[i].w);
      start = 1'b1;
      n0 = cyc;
      tick();
      start = 1'b0;
      k = 0; seen = 1'b0; ab = 1'b0; dcyc = -1;
      for (int t = 0; t < 2100 && !seen; t++) begin
        if (done) begin
          seen = 1'b1; ab = aborted; dcyc = cyc;
        end else begin
          if (pulse) begin
            if (k == vecs[i].abort_at) abort = 1'b1;
            k++;
          end
          tick();
          abort = 1'b0;
        end
      end
      chk($sformatf("vec%0d_done_seen", i), int'(seen), 1);
      chk($sformatf("vec%0d_pulse_len", i), k, vecs[i].exp_len);
      chk($sformatf("vec%0d_aborted", i), int'(ab), int'(vecs[i].exp_ab));
      chk($sformatf("vec%0d_done_cycle", i), dcyc - n0, vecs[i].exp_len + 1);
      repeat (2) tick();
    end

    // Second edge while active is ignored.
    pulse_cnt = 0; done_cnt = 0; width = WB'(6);
    start = 1'b1; tick(); start = 1'b0; tick(); start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    chk("retrigger_active_pulses", pulse_cnt, 6);
    chk("retrigger_active_dones", done_cnt, 1);

    // Start held high produces one pulse only.
    pulse_cnt = 0; width = WB'(3);
    start = 1'b1; repeat (15) tick(); start = 1'b0; tick();
    chk("held_start_pulses", pulse_cnt, 3);

    // Edge at N+W+1 (DONE) ignored; edge at N+W+2 accepted.
    width = WB'(3); n0 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick();
    chk("edge_in_done_ignored", int'(pulse), 0);
    tick();
    chk("held_after_done_no_retrigger", int'(pulse), 0);
    start = 1'b0; repeat (2) tick();
    n0 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    chk("earliest_edge_cycle", cyc - n0, 5);
    start = 1'b1; tick(); start = 1'b0;
    chk("earliest_edge_accepted", int'(pulse), 1);
    repeat (6) tick();

    // Reset at pulse cycle 20, start held through release.
    width = WB'(50); done_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    chk("reset_mid_remaining_before", int'(remaining), 31);
    rst_n = 1'b0; start = 1'b1; tick();
    chk("reset_mid_pulse", int'(pulse), 0);
    chk("reset_mid_busy", int'(busy), 0);
    chk("reset_mid_done", int'(done), 0);
    tick();
    rst_n = 1'b1; tick();
    chk("reset_release_new_pulse", int'(pulse), 1);
    chk("reset_release_remaining", int'(remaining), 50);
    start = 1'b0;
    repeat (55) tick();
    chk("reset_mid_done_count", done_cnt, 1);

    // Loopback into a duration counter.
    width = WB'(37); dur_fin = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    chk("loopback_count", dur_cnt, 36);
    chk("loopback_finished", int'(dur_fin), 1);

`ifdef PULSE_GEN_REPEAT_EN
    width = WB'(4); rep = 1'b1; n0 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    for (int o = 1; o <= 15; o++) begin
      chk($sformatf("repeat_pattern_o%0d", o), int'(pulse), int'((o % 5) != 0));
      tick();
    end
    rep = 1'b0;
    repeat (8) tick();
    chk("repeat_stopped", int'(busy), 0);
`endif

    for (int r = 0; r < 1500; r++) begin
      start = ($urandom_range(0, 3) == 0);
      width = WB'($urandom_range(0, 12));
      abort = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      rep   = $urandom_range(0, 1) != 0;
      tick();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; rep = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
